game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 20 ++
 rtl/bcd_counter4.sv | 40 ++++
 rtl/game_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the runner game: FSM encoding and default tuning values.
// Used by game_ctrl and the ground stage.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

  localparam int SPEED_INIT_DEF  = 4;
  localparam int SPEED_MAX_DEF   = 7;
  localparam int HOLD_FRAMES_DEF = 60;

  // One ramp step, held at the ceiling.
  function automatic logic [3:0] speed_step(input logic [3:0] cur, input logic [3:0] ceil_val);
    return (cur >= ceil_val) ? cur : cur + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with increment enable, synchronous clear, saturation at 9999
// and a pulse when a carry enters the hundreds digit.
module bcd_counter4 (
  input  logic        CLK,
  input  logic        N_rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count,
  output logic        hund_carry
);

  logic [3:0] carry;
  logic       saturated;

  assign saturated = (count == 16'h9999);
  assign carry[0]  = inc & ~saturated;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] digit_reg;

    always_ff @(posedge CLK or negedge N_rst) begin
      if (!N_rst) begin
        digit_reg <= 4'd0;
      end else if (clr) begin
        digit_reg <= 4'd0;
      end else if (carry[gi]) begin
        digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end
    end

    if (gi < 3) begin : g_chain
      assign carry[gi+1] = carry[gi] & (digit_reg == 4'd9);
    end

    assign count[gi*4 +: 4] = digit_reg;
  end

  assign hund_carry = carry[2];

endmodule

// File: rtl/game_ctrl.sv
// Game controller: IDLE/RUN/DEAD FSM, collision latch, frame-based scoring and lockout.
// Define GAME_CTRL_SPEED_RAMP_EN to raise speed on every carry into the hundreds digit.
module game_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SPEED_INIT       = SPEED_INIT_DEF,
  parameter int SPEED_MAX        = SPEED_MAX_DEF,
  parameter int HOLD_FRAMES      = HOLD_FRAMES_DEF
) (
  input  logic        CLK,
  input  logic        N_rst,
  input  logic        frame_tick,
  input  logic        btn,
  input  logic        dino_px,
  input  logic        obstacle_px,
  output logic        game_status,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        new_game,
  output logic [1:0]  state
);

`ifdef GAME_CTRL_SPEED_RAMP_EN
  localparam logic RAMP_EN = 1'b1;
`else
  localparam logic RAMP_EN = 1'b0;
`endif

  localparam logic [5:0] FRAME_LAST  = 6'(FRAMES_PER_POINT - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_FRAMES);
  localparam logic [3:0] SPEED_START = 4'(SPEED_INIT);
  localparam logic [3:0] SPEED_TOP   = 4'(SPEED_MAX);

  game_state_t state_reg, state_next;
  logic        btn_reg;
  logic        hit_reg;
  logic [5:0]  frame_cnt_reg;
  logic [7:0]  lock_cnt_reg;
  logic [3:0]  speed_reg;
  logic        game_status_reg;
  logic        new_game_reg;

  logic press, collision, dying, start_game, score_inc, hund_carry;

  always_comb begin
    press      = btn & ~btn_reg;
    collision  = dino_px & obstacle_px;
    dying      = (state_reg == ST_RUN) && frame_tick && (hit_reg || collision);
    state_next = state_reg;
    start_game = 1'b0;
    score_inc  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (press) begin
          state_next = ST_RUN;
          start_game = 1'b1;
        end
      end
      ST_RUN: begin
        if (dying) begin
          state_next = ST_DEAD;
        end else if (frame_tick && (frame_cnt_reg == FRAME_LAST)) begin
          score_inc = 1'b1;
        end
      end
      ST_DEAD: begin
        if (press && (lock_cnt_reg == HOLD_LAST)) begin
          state_next = ST_RUN;
          start_game = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // btn history resets high so a button held through reset is not a press.
  always_ff @(posedge CLK or negedge N_rst) begin
    if (!N_rst) begin
      state_reg       <= ST_IDLE;
      btn_reg         <= 1'b1;
      hit_reg         <= 1'b0;
      frame_cnt_reg   <= 6'd0;
      lock_cnt_reg    <= 8'd0;
      speed_reg       <= SPEED_START;
      game_status_reg <= 1'b0;
      new_game_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      btn_reg         <= btn;
      game_status_reg <= (state_next == ST_RUN);
      new_game_reg    <= start_game;
      hit_reg         <= (state_reg == ST_RUN) && !frame_tick && (hit_reg || collision);

      if (start_game) begin
        frame_cnt_reg <= 6'd0;
      end else if ((state_reg == ST_RUN) && frame_tick && !dying) begin
        frame_cnt_reg <= (frame_cnt_reg == FRAME_LAST) ? 6'd0 : frame_cnt_reg + 6'd1;
      end

      if (dying) begin
        lock_cnt_reg <= 8'd0;
      end else if ((state_reg == ST_DEAD) && frame_tick && (lock_cnt_reg != HOLD_LAST)) begin
        lock_cnt_reg <= lock_cnt_reg + 8'd1;
      end

      if (start_game) begin
        speed_reg <= SPEED_START;
      end else if (RAMP_EN && hund_carry) begin
        speed_reg <= speed_step(speed_reg, SPEED_TOP);
      end
    end
  end

  bcd_counter4 u_score (
    .CLK        (CLK),
    .N_rst      (N_rst),
    .clr        (start_game),
    .inc        (score_inc),
    .count      (score),
    .hund_carry (hund_carry)
  );

  assign state       = state_reg;
  assign game_status = game_status_reg;
  assign speed       = speed_reg;
  assign new_game    = new_game_reg;

endmodule
